// File: rtl/stream_demux_12.sv
// stream_demux_12
//   Receive-side decoder for the 48-bit tagged memory stream coming off the
//   inter-board link. Header words carry the event BX; data words are routed
//   to one of 12 destination memories through a shared data bus, a one-hot
//   write enable and a {bx, per-port count} write address. At every header
//   the previous event is closed and its word count reported.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   stream_in    [47:44] tag, [43:0] payload
//   dat_out      payload of the current write (held when no write)
//   we_out       one-hot write enable, bit k = port k
//   wr_addr      {bx_cur, port_count} (held when no write)
//   bx_cur       BX of the event being received
//   evt_done     1-cycle pulse: previous event closed
//   evt_bx       BX of the closed event
//   evt_nwords   words accepted in the closed event
//   err_no_hdr   pulse: data/reserved word dropped before the first header
//   err_tag      pulse: reserved tag dropped
//   err_ovf      pulse: data word dropped, port page full
//   err_bx_seq   pulse: header BX is not previous BX + 1 (mod 8)
//
// All outputs are registered: they reflect the word sampled on the
// previous rising edge.
module stream_demux_12 #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [47:0]       stream_in,
  output logic [43:0]       dat_out,
  output logic [11:0]       we_out,
  output logic [ADDR_W+2:0] wr_addr,
  output logic [2:0]        bx_cur,
  output logic              evt_done,
  output logic [2:0]        evt_bx,
  output logic [ADDR_W+3:0] evt_nwords,
  output logic              err_no_hdr,
  output logic              err_tag,
  output logic              err_ovf,
  output logic              err_bx_seq
);

  localparam int NP = 12;
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  typedef enum logic {WAIT_HDR, ACTIVE} state_t;

  state_t                       r_state;
  logic [NP-1:0][ADDR_W-1:0]    r_cnt;
  logic [ADDR_W+3:0]            r_total;

  logic [3:0]                   w_tag;
  logic [43:0]                  w_pay;
  logic [2:0]                   w_hdr_bx;
  logic                         w_hdr;
  logic                         w_rsvd;
  logic                         w_port_vld;
  logic [3:0]                   w_port;
  logic [ADDR_W-1:0]            w_cnt;

  assign w_tag    = stream_in[47:44];
  assign w_pay    = stream_in[43:0];
  assign w_hdr_bx = stream_in[43:41];
  assign w_hdr    = (w_tag == 4'hF);
  assign w_rsvd   = (w_tag == 4'hA) || (w_tag == 4'hE);

  // Tag to port map; 4'hA is skipped so ports 9..11 sit on B..D.
  always_comb begin
    w_port_vld = 1'b1;
    w_port     = 4'd0;
    case (w_tag)
      4'h1, 4'h2, 4'h3, 4'h4,
      4'h5, 4'h6, 4'h7, 4'h8: w_port = w_tag - 4'd1;
      4'h9:                   w_port = 4'd8;
      4'hB:                   w_port = 4'd9;
      4'hC:                   w_port = 4'd10;
      4'hD:                   w_port = 4'd11;
      default:                w_port_vld = 1'b0;
    endcase
  end

  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < NP; k++)
      if (w_port == 4'(k)) w_cnt = r_cnt[k];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= WAIT_HDR;
      r_cnt      <= '0;
      r_total    <= '0;
      dat_out    <= '0;
      we_out     <= '0;
      wr_addr    <= '0;
      bx_cur     <= '0;
      evt_done   <= 1'b0;
      evt_bx     <= '0;
      evt_nwords <= '0;
      err_no_hdr <= 1'b0;
      err_tag    <= 1'b0;
      err_ovf    <= 1'b0;
      err_bx_seq <= 1'b0;
    end else begin
      // pulses and write enable default low; dat_out/wr_addr hold
      we_out     <= '0;
      evt_done   <= 1'b0;
      err_no_hdr <= 1'b0;
      err_tag    <= 1'b0;
      err_ovf    <= 1'b0;
      err_bx_seq <= 1'b0;
      case (r_state)
        WAIT_HDR: begin
          if (w_hdr) begin
            bx_cur  <= w_hdr_bx;
            r_cnt   <= '0;
            r_total <= '0;
            r_state <= ACTIVE;
          end else if (w_port_vld || w_rsvd) begin
            err_no_hdr <= 1'b1;
          end
        end
        ACTIVE: begin
          if (w_hdr) begin
            evt_done   <= 1'b1;
            evt_bx     <= bx_cur;
            evt_nwords <= r_total;
            err_bx_seq <= (w_hdr_bx != 3'(bx_cur + 3'd1));
            bx_cur     <= w_hdr_bx;
            r_cnt      <= '0;
            r_total    <= '0;
          end else if (w_port_vld) begin
            // count == CNT_MAX means the page is full; top address unused
            if (w_cnt == CNT_MAX) begin
              err_ovf <= 1'b1;
            end else begin
              we_out          <= NP'(1) << w_port;
              dat_out         <= w_pay;
              wr_addr         <= {bx_cur, w_cnt};
              r_cnt[w_port]   <= w_cnt + 1'b1;
              r_total         <= r_total + 1'b1;
            end
          end else if (w_rsvd) begin
            err_tag <= 1'b1;
          end
        end
        default: r_state <= WAIT_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_demux_12.sv
// Scoreboard bench for stream_demux_12. Each eventful stimulus word pushes
// the response expected one cycle later; a monitor pops and compares
// whenever the DUT shows a write, an event close or an error pulse.
module tb_stream_demux_12;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [47:0]       stream_in = '0;
  logic [43:0]       dat_out;
  logic [11:0]       we_out;
  logic [ADDR_W+2:0] wr_addr;
  logic [2:0]        bx_cur;
  logic              evt_done;
  logic [2:0]        evt_bx;
  logic [ADDR_W+3:0] evt_nwords;
  logic              err_no_hdr, err_tag, err_ovf, err_bx_seq;

  stream_demux_12 #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .stream_in(stream_in),
    .dat_out(dat_out), .we_out(we_out), .wr_addr(wr_addr), .bx_cur(bx_cur),
    .evt_done(evt_done), .evt_bx(evt_bx), .evt_nwords(evt_nwords),
    .err_no_hdr(err_no_hdr), .err_tag(err_tag), .err_ovf(err_ovf),
    .err_bx_seq(err_bx_seq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0]       we;
    logic [43:0]       dat;
    logic [ADDR_W+2:0] addr;
    logic [2:0]        bx;
    logic              done;
    logic [2:0]        ebx;
    logic [ADDR_W+3:0] nw;
    logic [3:0]        errs; // {no_hdr, tag, ovf, bx_seq}
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // bench-side view of held outputs
  logic [2:0]        m_bx = '0;
  logic [43:0]       m_dat = '0;
  logic [ADDR_W+2:0] m_addr = '0;
  logic [2:0]        m_ebx = '0;
  logic [ADDR_W+3:0] m_nw = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (reset_n && (we_out != 0 || evt_done || err_no_hdr || err_tag || err_ovf || err_bx_seq)) begin
      exp_t e;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: we=%h done=%b errs=%b%b%b%b", we_out, evt_done,
                 err_no_hdr, err_tag, err_ovf, err_bx_seq);
      end else begin
        e = exp_q.pop_front();
        if (we_out !== e.we || dat_out !== e.dat || wr_addr !== e.addr || bx_cur !== e.bx ||
            evt_done !== e.done || evt_bx !== e.ebx || evt_nwords !== e.nw ||
            {err_no_hdr, err_tag, err_ovf, err_bx_seq} !== e.errs) begin
          n_fail++;
          $display("FAIL scoreboard: got we=%h dat=%h addr=%h bx=%0d done=%b ebx=%0d nw=%0d errs=%b%b%b%b expected we=%h dat=%h addr=%h bx=%0d done=%b ebx=%0d nw=%0d errs=%b",
                   we_out, dat_out, wr_addr, bx_cur, evt_done, evt_bx, evt_nwords,
                   err_no_hdr, err_tag, err_ovf, err_bx_seq,
                   e.we, e.dat, e.addr, e.bx, e.done, e.ebx, e.nw, e.errs);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] tag, input logic [43:0] pay);
    @(negedge clk);
    stream_in = {tag, pay};
  endtask

  task automatic push(input logic [11:0] we, input logic done, input logic [3:0] errs);
    exp_t e;
    e.we = we; e.dat = m_dat; e.addr = m_addr; e.bx = m_bx;
    e.done = done; e.ebx = m_ebx; e.nw = m_nw; e.errs = errs;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'h0, 44'h0);
  endtask

  task automatic hdr_wait(input logic [2:0] bx);
    drive(4'hF, {bx, 41'h0});
    m_bx = bx;
  endtask

  task automatic hdr_act(input logic [2:0] bx, input logic [2:0] ebx,
                         input int nw, input logic seq);
    drive(4'hF, {bx, 41'h1ABCD});
    m_bx = bx; m_ebx = ebx; m_nw = (ADDR_W+4)'(nw);
    push('0, 1'b1, {3'b000, seq});
  endtask

  task automatic wr(input logic [3:0] tag, input logic [43:0] pay,
                    input int port, input int cnt);
    drive(tag, pay);
    m_dat = pay; m_addr = {m_bx, ADDR_W'(cnt)};
    push(12'(1) << port, 1'b0, 4'b0000);
  endtask

  task automatic err(input logic [3:0] tag, input logic [3:0] errs);
    drive(tag, 44'hFFF_0000_1111);
    push('0, 1'b0, errs);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_we"},    64'(we_out), 64'h0);
    check({nm, "_dat"},   64'(dat_out), 64'h0);
    check({nm, "_addr"},  64'(wr_addr), 64'h0);
    check({nm, "_bx"},    64'(bx_cur), 64'h0);
    check({nm, "_pulse"}, 64'({evt_done, err_no_hdr, err_tag, err_ovf, err_bx_seq}), 64'h0);
    check({nm, "_evt"},   64'({evt_bx, evt_nwords}), 64'h0);
  endtask

  task automatic clear_model();
    m_bx = '0; m_dat = '0; m_addr = '0; m_ebx = '0; m_nw = '0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;

    // 1: idle then first header
    idle(3);
    hdr_wait(3'd3);
    idle(1);
    check("hdr_bx_cur", 64'(bx_cur), 64'd3);
    check("hdr_no_done", 64'({evt_done, we_out}), 64'h0);

    // 2: routing of tags 1, 9, B
    wr(4'h1, 44'h123, 0, 0);
    wr(4'h9, 44'h123, 8, 0);
    wr(4'hB, 44'h123, 9, 0);
    idle(1);

    // 3: port page saturation; 3 != 3+1 so seq error on this header
    hdr_act(3'd3, 3'd3, 3, 1'b1);
    for (int i = 0; i < 63; i++) wr(4'h2, 44'(i) + 44'h500, 1, i);
    err(4'h2, 4'b0010);
    hdr_act(3'd4, 3'd3, 63, 1'b0);

    // 4: BX sequence
    hdr_act(3'd7, 3'd4, 0, 1'b1);
    hdr_act(3'd0, 3'd7, 0, 1'b0);
    hdr_act(3'd2, 3'd0, 0, 1'b1);
    idle(2);

    // 5: words before header, reserved tags
    reset_n = 1'b0;
    clear_model();
    @(negedge clk);
    check_zero("reset2");
    reset_n = 1'b1;
    err(4'h5, 4'b1000);
    err(4'hA, 4'b1000);
    hdr_wait(3'd1);
    err(4'hA, 4'b0100);
    err(4'hE, 4'b0100);
    wr(4'hD, 44'hABC, 11, 0);
    idle(1);

    // 6: async reset mid-event
    for (int i = 0; i < 5; i++) wr(4'h1, 44'h900 + 44'(i), 0, i);
    idle(2);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero("async_rst");
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;
    hdr_wait(3'd5);
    wr(4'h1, 44'h55, 0, 0);
    wr(4'hC, 44'h66, 10, 0);
    idle(3);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
